// File: rtl/swervolf_brcnt_pkg.sv
// Shared definitions for the branch-statistics counter block: register offsets,
// CTRL bit positions and the counting state enum.
package swervolf_brcnt_pkg;

   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_BRANCHES = 2'd1;
   localparam logic [1:0] REG_TAKEN    = 2'd2;
   localparam logic [1:0] REG_MISPRED  = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;
   localparam int CTRL_FREEZE = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } brcnt_state_e;

   // CTRL image as seen by software; clear is a strobe and always reads 0
   function automatic logic [31:0] ctrl_image(input logic enable, input logic freeze);
      ctrl_image = {29'd0, freeze, 1'b0, enable};
   endfunction

endpackage

// File: rtl/swervolf_brcnt_ctr.sv
// One 32-bit event counter with synchronous clear (priority over increment)
// and a choice of saturating or wrapping behaviour at the top value.
module swervolf_brcnt_ctr
   import swervolf_brcnt_pkg::*;
#(
   parameter int SATURATE = 1
) (
   input  logic        clk_core,
   input  logic        rstn,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] cnt
);

   logic [31:0] cnt_r;

   // Counter register: clear beats increment, top value either sticks or wraps
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= 32'd0;
      end else if (clr) begin
         cnt_r <= 32'd0;
      end else if (inc) begin
         if ((SATURATE != 0) && (cnt_r == 32'hFFFF_FFFF)) begin
            cnt_r <= cnt_r;
         end else begin
            cnt_r <= cnt_r + 32'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/swervolf_branch_cnt.sv
// Retired-branch statistics peripheral on a Wishbone classic slave port.
// Optional macro SWERVOLF_BRCNT_MISPRED_EN adds the mispredict counter.
module swervolf_branch_cnt
   import swervolf_brcnt_pkg::*;
#(
   parameter int SATURATE   = 1,
   parameter int RST_ENABLE = 1
) (
   input  logic        clk_core,
   input  logic        rstn,
   input  logic        i_br_valid,
   input  logic        i_br_taken,
   input  logic        i_br_mispred,
   input  logic [3:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic [31:0] o_branches,
   output logic [31:0] o_taken
);

   logic         ack_r;
   logic         armed_r;
   logic [31:0]  rdt_r;
   logic         enable_r;
   logic         freeze_r;
   logic         enable_next_s;
   logic         freeze_next_s;
   brcnt_state_e state_r;
   brcnt_state_e state_next_s;
   logic [31:0]  branches_s;
   logic [31:0]  taken_s;
   logic [31:0]  shadow_taken_r;
   logic [31:0]  mispred_rd_s;
   logic [31:0]  rd_data_s;

   // A request is only taken once the bus has been seen idle after reset
   wire         req_s      = i_wb_cyc & i_wb_stb;
   wire         access_s   = req_s & ~ack_r & armed_r;
   wire         rd_s       = access_s & ~i_wb_we;
   wire  [1:0]  reg_s      = i_wb_adr[3:2];
   wire         ctrl_wr_s  = access_s & i_wb_we & (reg_s == REG_CTRL) & i_wb_sel[0];
   wire         clear_s    = ctrl_wr_s & i_wb_dat[CTRL_CLEAR];
   wire         snap_s     = rd_s & (reg_s == REG_BRANCHES);
   wire         count_s    = (state_r == RUN) & i_br_valid;

   // Next CTRL contents from a byte-0 write
   always_comb begin
      enable_next_s = enable_r;
      freeze_next_s = freeze_r;
      if (ctrl_wr_s) begin
         enable_next_s = i_wb_dat[CTRL_ENABLE];
         freeze_next_s = i_wb_dat[CTRL_FREEZE];
      end else begin
         enable_next_s = enable_r;
         freeze_next_s = freeze_r;
      end
   end

   // Next counting state, derived from the CTRL value being written
   always_comb begin
      state_next_s = IDLE;
      case ({enable_next_s, freeze_next_s})
         2'b10:   state_next_s = RUN;
         2'b11:   state_next_s = FROZEN;
         default: state_next_s = IDLE;
      endcase
   end

   // CTRL and state registers
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         enable_r <= (RST_ENABLE != 0);
         freeze_r <= 1'b0;
         state_r  <= (RST_ENABLE != 0) ? RUN : IDLE;
      end else begin
         enable_r <= enable_next_s;
         freeze_r <= freeze_next_s;
         state_r  <= state_next_s;
      end
   end

   swervolf_brcnt_ctr #(.SATURATE(SATURATE)) u_branches (
      .clk_core (clk_core),
      .rstn     (rstn),
      .inc      (count_s),
      .clr      (clear_s),
      .cnt      (branches_s)
   );

   swervolf_brcnt_ctr #(.SATURATE(SATURATE)) u_taken (
      .clk_core (clk_core),
      .rstn     (rstn),
      .inc      (count_s & i_br_taken),
      .clr      (clear_s),
      .cnt      (taken_s)
   );

   // Taken shadow, captured by a BRANCHES read so the triple reads coherently
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         shadow_taken_r <= 32'd0;
      end else if (clear_s) begin
         shadow_taken_r <= 32'd0;
      end else if (snap_s) begin
         shadow_taken_r <= taken_s;
      end else begin
         shadow_taken_r <= shadow_taken_r;
      end
   end

`ifdef SWERVOLF_BRCNT_MISPRED_EN
   logic [31:0] mispred_s;
   logic [31:0] shadow_mispred_r;

   swervolf_brcnt_ctr #(.SATURATE(SATURATE)) u_mispred (
      .clk_core (clk_core),
      .rstn     (rstn),
      .inc      (count_s & i_br_mispred),
      .clr      (clear_s),
      .cnt      (mispred_s)
   );

   // Mispredict shadow, captured alongside the taken shadow
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         shadow_mispred_r <= 32'd0;
      end else if (clear_s) begin
         shadow_mispred_r <= 32'd0;
      end else if (snap_s) begin
         shadow_mispred_r <= mispred_s;
      end else begin
         shadow_mispred_r <= shadow_mispred_r;
      end
   end

   assign mispred_rd_s = shadow_mispred_r;
   wire unused_s = ^{i_wb_dat[31:3], i_wb_sel[3:1], i_wb_adr[1:0]};
`else
   assign mispred_rd_s = 32'd0;
   wire unused_s = ^{i_wb_dat[31:3], i_wb_sel[3:1], i_wb_adr[1:0], i_br_mispred};
`endif

   // Read data selection
   always_comb begin
      rd_data_s = 32'd0;
      case (reg_s)
         REG_CTRL:     rd_data_s = ctrl_image(enable_r, freeze_r);
         REG_BRANCHES: rd_data_s = branches_s;
         REG_TAKEN:    rd_data_s = shadow_taken_r;
         REG_MISPRED:  rd_data_s = mispred_rd_s;
         default:      rd_data_s = 32'd0;
      endcase
   end

   // Bus handshake: single-cycle ack, registered read data zero outside ack
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         ack_r   <= 1'b0;
         armed_r <= 1'b0;
         rdt_r   <= 32'd0;
      end else begin
         ack_r   <= access_s;
         armed_r <= armed_r | ~req_s;
         rdt_r   <= rd_s ? rd_data_s : 32'd0;
      end
   end

   assign o_wb_ack   = ack_r;
   assign o_wb_rdt   = rdt_r;
   assign o_branches = branches_s;
   assign o_taken    = taken_s;

endmodule

// File: tb/tb_swervolf_branch_cnt.sv
// Directed bench for swervolf_branch_cnt: a table of bus accesses plus
// hand-written sequences for freeze, clear collision, shadows, saturation and reset.
module tb_swervolf_branch_cnt;

   logic        clk_core = 1'b0;
   logic        rstn = 1'b0;
   logic        i_br_valid = 1'b0;
   logic        i_br_taken = 1'b0;
   logic        i_br_mispred = 1'b0;
   logic [3:0]  i_wb_adr = 4'd0;
   logic [31:0] i_wb_dat = 32'd0;
   logic [3:0]  i_wb_sel = 4'd0;
   logic        i_wb_we = 1'b0;
   logic        i_wb_cyc = 1'b0;
   logic        i_wb_stb = 1'b0;
   logic [31:0] o_wb_rdt, w_wb_rdt;
   logic        o_wb_ack, w_wb_ack;
   logic [31:0] o_branches, w_branches;
   logic [31:0] o_taken, w_taken;

   int checks = 0;
   int errors = 0;

   always #5 clk_core = ~clk_core;

   swervolf_branch_cnt #(.SATURATE(1), .RST_ENABLE(1)) dut (
      .clk_core(clk_core), .rstn(rstn),
      .i_br_valid(i_br_valid), .i_br_taken(i_br_taken), .i_br_mispred(i_br_mispred),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
      .o_branches(o_branches), .o_taken(o_taken)
   );

   swervolf_branch_cnt #(.SATURATE(0), .RST_ENABLE(1)) dut_wrap (
      .clk_core(clk_core), .rstn(rstn),
      .i_br_valid(i_br_valid), .i_br_taken(i_br_taken), .i_br_mispred(i_br_mispred),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
      .o_wb_rdt(w_wb_rdt), .o_wb_ack(w_wb_ack),
      .o_branches(w_branches), .o_taken(w_taken)
   );

   typedef struct {
      logic [3:0]  adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] exp_rdt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus access; ack is awaited for at most 4 cycles
   task automatic wb_xfer(input logic [3:0] adr, input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, output logic [31:0] rd);
      int n = 0;
      @(negedge clk_core);
      i_wb_adr = adr; i_wb_dat = dat; i_wb_we = we; i_wb_sel = sel;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      do begin
         @(posedge clk_core); #1;
         n++;
      end while (!o_wb_ack && n < 4);
      chk("wb_ack", {31'd0, o_wb_ack}, 32'd1);
      rd = o_wb_rdt;
      @(negedge clk_core);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [3:0] adr, input string name, input logic [31:0] exp);
      logic [31:0] rd;
      wb_xfer(adr, 32'd0, 1'b0, 4'hF, rd);
      chk(name, rd, exp);
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
      logic [31:0] rd;
      wb_xfer(adr, dat, 1'b1, 4'h1, rd);
   endtask

   task automatic branches(input int n, input int n_taken);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_core);
         i_br_valid = 1'b1; i_br_taken = (i < n_taken); i_br_mispred = 1'b1;
      end
      @(negedge clk_core);
      i_br_valid = 1'b0; i_br_taken = 1'b0; i_br_mispred = 1'b0;
   endtask

   vec_t tbl[15];

   initial begin
      logic [31:0] rd;

      tbl[0]  = '{4'h0, 32'h0,  1'b0, 4'hF, 32'h1};
      tbl[1]  = '{4'h8, 32'h0,  1'b0, 4'hF, 32'h0};
      tbl[2]  = '{4'h4, 32'h0,  1'b0, 4'hF, 32'd10};
      tbl[3]  = '{4'h8, 32'h0,  1'b0, 4'hF, 32'd4};
      tbl[4]  = '{4'hC, 32'h0,  1'b0, 4'hF, 32'h0};
      tbl[5]  = '{4'h4, 32'h55, 1'b1, 4'hF, 32'h0};
      tbl[6]  = '{4'h8, 32'h77, 1'b1, 4'hF, 32'h0};
      tbl[7]  = '{4'h4, 32'h0,  1'b0, 4'hF, 32'd10};
      tbl[8]  = '{4'h8, 32'h0,  1'b0, 4'hF, 32'd4};
      tbl[9]  = '{4'h0, 32'h0,  1'b1, 4'hE, 32'h0};
      tbl[10] = '{4'h0, 32'h0,  1'b0, 4'hF, 32'h1};
      tbl[11] = '{4'h0, 32'h5,  1'b1, 4'h1, 32'h0};
      tbl[12] = '{4'h0, 32'h0,  1'b0, 4'hF, 32'h5};
      tbl[13] = '{4'h0, 32'h1,  1'b1, 4'h1, 32'h0};
      tbl[14] = '{4'h0, 32'h0,  1'b0, 4'hF, 32'h1};

      // Reset values
      repeat (2) @(posedge clk_core);
      #1;
      chk("rst_branches", o_branches, 32'd0);
      chk("rst_taken", o_taken, 32'd0);
      chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
      chk("rst_rdt", o_wb_rdt, 32'd0);
      @(negedge clk_core);
      rstn = 1'b1;

      // 10 branches, 4 taken, mispredict ignored in this build
      branches(10, 4);
      chk("live_branches", o_branches, 32'd10);
      chk("live_taken", o_taken, 32'd4);

      for (int i = 0; i < 15; i++) begin
         wb_xfer(tbl[i].adr, tbl[i].dat, tbl[i].we, tbl[i].sel, rd);
         chk($sformatf("tbl[%0d]", i), rd, tbl[i].exp_rdt);
      end

      // Freeze holds the counts, unfreeze resumes
      wb_write(4'h0, 32'h5);
      branches(5, 5);
      chk("frozen_branches", o_branches, 32'd10);
      chk("frozen_taken", o_taken, 32'd4);
      wb_write(4'h0, 32'h1);
      branches(5, 5);
      chk("resume_branches", o_branches, 32'd15);
      chk("resume_taken", o_taken, 32'd9);

      // Shadow coherence: TAKEN reads the value captured at the BRANCHES read
      wb_read(4'h4, "snap_branches", 32'd15);
      branches(3, 3);
      wb_read(4'h8, "shadow_taken", 32'd9);
      chk("live_taken_after", o_taken, 32'd12);
      wb_read(4'h4, "snap2_branches", 32'd18);
      wb_read(4'h8, "shadow2_taken", 32'd12);

      // Held request: ack alternates, never two consecutive cycles
      @(negedge clk_core);
      i_wb_adr = 4'h0; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      @(posedge clk_core); #1;
      chk("held_ack1", {31'd0, o_wb_ack}, 32'd1);
      @(posedge clk_core); #1;
      chk("held_ack2", {31'd0, o_wb_ack}, 32'd0);
      chk("held_rdt_idle", o_wb_rdt, 32'd0);
      @(posedge clk_core); #1;
      chk("held_ack3", {31'd0, o_wb_ack}, 32'd1);
      @(negedge clk_core);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;

      // Clear written in the same cycle as a taken branch
      @(negedge clk_core);
      i_wb_adr = 4'h0; i_wb_dat = 32'h3; i_wb_we = 1'b1; i_wb_sel = 4'h1;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      i_br_valid = 1'b1; i_br_taken = 1'b1;
      @(posedge clk_core); #1;
      chk("clr_ack", {31'd0, o_wb_ack}, 32'd1);
      chk("clr_branches", o_branches, 32'd0);
      chk("clr_taken", o_taken, 32'd0);
      @(negedge clk_core);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      i_br_valid = 1'b0; i_br_taken = 1'b0;
      wb_read(4'h8, "clr_shadow", 32'd0);
      wb_read(4'h0, "clr_ctrl", 32'h1);

      // Saturate vs wrap from a preloaded 0xFFFFFFFE
      @(negedge clk_core);
      force dut.u_branches.cnt_r = 32'hFFFF_FFFE;
      force dut_wrap.u_branches.cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.u_branches.cnt_r;
      release dut_wrap.u_branches.cnt_r;
      chk("preload", o_branches, 32'hFFFF_FFFE);
      branches(3, 0);
      chk("sat_branches", o_branches, 32'hFFFF_FFFF);
      chk("wrap_branches", w_branches, 32'h0000_0001);
      chk("sat_taken_indep", o_taken, 32'd0);
      wb_read(4'h4, "sat_read", 32'hFFFF_FFFF);

      // Reset during a pending request drops it
      wb_write(4'h0, 32'h4);
      wb_read(4'h0, "pre_rst_ctrl", 32'h4);
      @(negedge clk_core);
      i_wb_adr = 4'h4; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      #2 rstn = 1'b0;
      @(posedge clk_core); #1;
      chk("rst_mid_ack", {31'd0, o_wb_ack}, 32'd0);
      chk("rst_mid_branches", o_branches, 32'd0);
      chk("rst_mid_rdt", o_wb_rdt, 32'd0);
      @(negedge clk_core);
      rstn = 1'b1;
      repeat (2) begin
         @(posedge clk_core); #1;
         chk("stale_req_ack", {31'd0, o_wb_ack}, 32'd0);
      end
      @(negedge clk_core);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      wb_read(4'h0, "post_rst_ctrl", 32'h1);
      branches(4, 1);
      wb_read(4'h4, "post_rst_branches", 32'd4);
      wb_read(4'h8, "post_rst_taken", 32'd1);
      wb_read(4'hC, "mispred_absent", 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/swervolf_branch_cnt.md
SWERVOLF_BRANCH_CNT -- requirements
Module: swervolf_branch_cnt

Interface
REQ-001 SHALL have parameter SATURATE, default 1: 1 = counters stick at 32'hFFFFFFFF; 0 = counters wrap to 0.
REQ-002 SHALL have parameter RST_ENABLE, default 1: reset value of CTRL.enable.
REQ-003 clk_core  in  1  core clock; all logic is clocked on its rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 i_br_valid  in  1  one retired branch this cycle.
REQ-006 i_br_taken  in  1  the retired branch was taken; qualified by i_br_valid.
REQ-007 i_br_mispred  in  1  the retired branch was mispredicted; qualified by i_br_valid.
REQ-008 i_wb_adr  in  4  Wishbone byte address; bits [3:2] select the register.
REQ-009 i_wb_dat  in  32  Wishbone write data.
REQ-010 i_wb_sel  in  4  byte enables; only byte 0 is used, and only for CTRL.
REQ-011 i_wb_we, i_wb_cyc, i_wb_stb  in  1 each  Wishbone classic controls.
REQ-012 o_wb_rdt  out  32  read data; o_wb_ack  out  1  cycle acknowledge.
REQ-013 o_branches, o_taken  out  32 each  live counter values for the seven-segment display.

Function
REQ-014 Register map: 0x0 CTRL (bit0 enable, bit1 clear, bit2 freeze), 0x4 BRANCHES, 0x8 TAKEN, 0xC MISPRED.
REQ-015 When enable=1 and freeze=0, each i_br_valid cycle SHALL increment BRANCHES by 1, increment TAKEN if i_br_taken, and increment MISPRED if i_br_mispred; the new value is visible the next cycle.
REQ-016 Counter state machine states: IDLE (enable=0), RUN (enable=1, freeze=0), FROZEN (enable=1, freeze=1); only RUN counts; state follows CTRL with zero latency after the write.
REQ-017 Writing CTRL with bit1=1 SHALL zero all three counters and their shadows on the write cycle; bit1 reads back 0.
REQ-018 If a clear and a branch event occur in the same cycle, clear SHALL win and the counters SHALL be 0 on the next cycle.
REQ-019 At 32'hFFFFFFFF with SATURATE=1, a counter SHALL hold; with SATURATE=0 it SHALL wrap to 0; each counter behaves independently.
REQ-020 A read of BRANCHES SHALL copy TAKEN and MISPRED into shadow registers in the same cycle; subsequent reads of 0x8/0xC SHALL return the shadows, giving a coherent triple.
REQ-021 o_wb_ack SHALL assert for exactly one cycle, one cycle after cyc&stb is sampled with ack low; it is never asserted on two consecutive cycles.
REQ-022 o_wb_rdt SHALL be registered and valid with ack; it is 0 when ack is low.
REQ-023 Writes to 0x4/0x8/0xC SHALL be acked and ignored.
REQ-024 o_branches and o_taken SHALL be the live counters, not the shadows.

Reset
REQ-025 On rstn low: all counters and shadows are 0; CTRL = {freeze=0, clear=0, enable=RST_ENABLE}; o_wb_ack = 0; o_wb_rdt = 0.
REQ-026 If reset is asserted mid-transaction, the transaction SHALL be dropped with no ack; the first ack after reset release requires a fresh cyc&stb.

Configuration
REQ-027 Macro SWERVOLF_BRCNT_MISPRED_EN: when defined, the MISPRED counter and its shadow are implemented.
REQ-028 Without SWERVOLF_BRCNT_MISPRED_EN: i_br_mispred is ignored, 0xC reads 0, and no MISPRED flops exist.

Structure
REQ-029 Shared package swervolf_brcnt_pkg SHALL hold the register offsets, CTRL bit indices and the state enum (IDLE/RUN/FROZEN).
REQ-030 Sub-module swervolf_brcnt_ctr SHALL be one 32-bit counter (inc, clr, SATURATE), instantiated 2 or 3 times.

Verification
REQ-031 Reset; 10 i_br_valid pulses with taken on 4 -> read 0x4=10, 0x8=4.
REQ-032 Preload to 0xFFFFFFFE via 2^32-2 pulses, or force in the bench; 3 more pulses -> SATURATE=1 reads 0xFFFFFFFF; SATURATE=0 reads 0x00000001.
REQ-033 CTRL=0x1 then 0x5 (freeze); 5 branches -> counts unchanged; CTRL=0x1, 5 branches -> +5.
REQ-034 Write CTRL=0x3 in the same cycle as i_br_valid=1, i_br_taken=1 -> all counters 0 next cycle.
REQ-035 Read 0x4; 3 taken branches; read 0x8 -> returns the value before the 3 branches; o_taken shows +3.
REQ-036 Assert rstn low while cyc&stb is pending -> no ack, all registers at reset values; with the macro undefined, 0xC reads 0 after mispredict pulses.
